// File: rtl/pattern_matcher.sv
// pattern_matcher: serial-programmed bit-pattern matcher with don't-care mask
// and error tolerance.
//   clk          - single clock, all state changes on the rising edge
//   clr          - asynchronous active-low reset
//   prgm_en      - shift prgm/mask into the pattern/mask registers
//   prgm, mask   - serial pattern bit and don't-care bit (1 = ignore)
//   sig_valid    - shift sig into the signal window
//   sig          - serial signal bit
//   cnt_clr      - synchronous clear of match_count
//   armed        - high while comparing (state RUN)
//   match        - registered one-cycle match pulse
//   match_count  - saturating count of match pulses
module pattern_matcher #(
    parameter int WIDTH   = 64,
    parameter int MAX_ERR = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             prgm_en,
    input  logic             prgm,
    input  logic             mask,
    input  logic             sig_valid,
    input  logic             sig,
    input  logic             cnt_clr,
    output logic             armed,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, PROG, FILL, RUN} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] pat_q, msk_q, sig_q, sig_d;
    logic [CW-1:0]   prog_cnt_q, prog_cnt_d;
    logic [CW-1:0]   fill_cnt_q, fill_cnt_d;
    logic [31:0]     err;
    logic            hit;
    logic            match_d;

    // The window is judged after this cycle's shift, so compare against the
    // next signal value rather than the registered one.
    assign sig_d = sig_valid ? {sig_q[WIDTH-2:0], sig} : sig_q;

    always_comb begin
        err = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            err = err + 32'((pat_q[i] ^ sig_d[i]) & ~msk_q[i]);
        end
    end

    assign hit   = (err <= 32'(MAX_ERR));
    assign armed = (state_q == RUN);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pat_q <= '0;
            msk_q <= '0;
            sig_q <= '0;
        end else begin
            if (prgm_en) begin
                pat_q <= {pat_q[WIDTH-2:0], prgm};
                msk_q <= {msk_q[WIDTH-2:0], mask};
            end
            sig_q <= sig_d;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            prog_cnt_q <= '0;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prog_cnt_q <= prog_cnt_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prog_cnt_d = prog_cnt_q;
        fill_cnt_d = fill_cnt_q;
        match_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (prgm_en) begin
                    state_d    = PROG;
                    prog_cnt_d = ONE;
                end
            end
            PROG: begin
                if (prgm_en) begin
                    prog_cnt_d = prog_cnt_q + ONE;
                    if (prog_cnt_q == LAST) begin
                        state_d    = FILL;
                        fill_cnt_d = '0;
                    end
                end
            end
            FILL: begin
                if (prgm_en) begin
                    state_d    = PROG;
                    prog_cnt_d = ONE;
                end else if (sig_valid) begin
                    fill_cnt_d = fill_cnt_q + ONE;
                    if (fill_cnt_q == LAST) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (prgm_en) begin
                    state_d    = PROG;
                    prog_cnt_d = ONE;
                end else begin
                    match_d = sig_valid & hit;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The counter advances on the edge that ends a visible match pulse, so a
    // cnt_clr in the pulse cycle wins over that pulse's increment.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= match_d;
            if (cnt_clr) begin
                match_count <= '0;
            end else if (match && (match_count != '1)) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_matcher.sv
module tb_pattern_matcher;

    logic clk = 1'b0;
    logic clr, prgm_en, prgm, mask, sig_valid, sig, cnt_clr;
    logic armed0, armed1, match0, match1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_matcher #(.WIDTH(8), .MAX_ERR(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .clr(clr), .prgm_en(prgm_en), .prgm(prgm), .mask(mask),
        .sig_valid(sig_valid), .sig(sig), .cnt_clr(cnt_clr),
        .armed(armed0), .match(match0), .match_count(cnt0)
    );

    pattern_matcher #(.WIDTH(8), .MAX_ERR(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .clr(clr), .prgm_en(prgm_en), .prgm(prgm), .mask(mask),
        .sig_valid(sig_valid), .sig(sig), .cnt_clr(cnt_clr),
        .armed(armed1), .match(match1), .match_count(cnt1)
    );

    // Reference model: bit vectors, programmed/filled bit tallies and the
    // popcount rule. Both DUTs see identical inputs; only tolerance and
    // counter width differ.
    bit [7:0]    m_pat, m_msk, m_sig;
    int          m_prog, m_fill;
    bit          m_armed;
    bit          m_match [2];
    logic [15:0] m_cnt [2];
    int          me [2] = '{0, 1};
    logic [15:0] cmax [2] = '{16'hFFFF, 16'd3};

    task automatic reset_model();
        m_pat = '0; m_msk = '0; m_sig = '0;
        m_prog = 0; m_fill = 0; m_armed = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_match[d] = 1'b0;
            m_cnt[d]   = '0;
        end
    endtask

    // Drive one cycle of inputs, advance the model, and return #1 after the edge.
    task automatic step(input bit pe, input bit p, input bit m,
                        input bit sv, input bit s, input bit cc);
        bit eval;
        prgm_en = pe; prgm = p; mask = m; sig_valid = sv; sig = s; cnt_clr = cc;
        for (int d = 0; d < 2; d++) begin
            if (cc) m_cnt[d] = '0;
            else if (m_match[d] && m_cnt[d] != cmax[d]) m_cnt[d] = m_cnt[d] + 1'b1;
        end
        if (sv) m_sig = {m_sig[6:0], s};
        eval = m_armed && sv && !pe;
        if (pe) begin
            m_pat   = {m_pat[6:0], p};
            m_msk   = {m_msk[6:0], m};
            m_prog  = (m_prog == 0 || m_prog == 8) ? 1 : m_prog + 1;
            m_fill  = 0;
            m_armed = 1'b0;
        end else if (m_prog == 8 && !m_armed && sv) begin
            m_fill = m_fill + 1;
            if (m_fill == 8) m_armed = 1'b1;
        end
        for (int d = 0; d < 2; d++)
            m_match[d] = eval && ($countones((m_pat ^ m_sig) & ~m_msk) <= me[d]);
        @(posedge clk);
        #1;
    endtask

    task automatic prog_byte(input logic [7:0] p, input logic [7:0] m);
        for (int i = 7; i >= 0; i--) step(1'b1, p[i], m[i], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic stream_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) step(1'b0, 1'b0, 1'b0, 1'b1, b[i], 1'b0);
    endtask

    task automatic test_reset();
        clr = 1'b0; prgm_en = 0; prgm = 0; mask = 0; sig_valid = 0; sig = 0; cnt_clr = 0;
        reset_model();
        #3;
        checks++;
        if (armed0 !== 1'b0 || match0 !== 1'b0 || cnt0 !== 16'd0 ||
            armed1 !== 1'b0 || match1 !== 1'b0 || cnt1 !== 2'd0) begin
            errors++;
            $display("FAIL reset_state armed=%b/%b match=%b/%b cnt=%0d/%0d expected all 0",
                     armed0, armed1, match0, match1, cnt0, cnt1);
        end
        @(posedge clk); @(posedge clk);
        #2 clr = 1'b1;
    endtask

    task automatic test_basic();
        prog_byte(8'hA5, 8'h00);
        checks++;
        if (armed0 !== 1'b0) begin
            errors++; $display("FAIL basic_armed_in_fill got=%b expected=0", armed0);
        end
        fill_zero();
        checks++;
        if (armed0 !== 1'b1 || match0 !== 1'b0) begin
            errors++; $display("FAIL basic_fill_done armed=%b match=%b expected armed=1 match=0", armed0, match0);
        end
        stream_byte(8'hA5);
        checks++;
        if (match0 !== 1'b1) begin
            errors++; $display("FAIL basic_match got=%b expected=1", match0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (match0 !== 1'b0 || cnt0 !== 16'd1) begin
            errors++; $display("FAIL basic_count match=%b cnt=%0d expected match=0 cnt=1", match0, cnt0);
        end
        checks++;
        if (match1 !== m_match[1] || {14'b0, cnt1} !== m_cnt[1]) begin
            errors++; $display("FAIL basic_dut1 match=%b cnt=%0d expected match=%b cnt=%0d", match1, cnt1, m_match[1], m_cnt[1]);
        end
    endtask

    task automatic test_mask();
        prog_byte(8'hA5, 8'h0F);
        fill_zero();
        stream_byte(8'hA3);
        checks++;
        if (match0 !== 1'b1) begin
            errors++; $display("FAIL mask_window_A3 got=%b expected=1", match0);
        end
        stream_byte(8'hB5);
        checks++;
        if (match0 !== 1'b0) begin
            errors++; $display("FAIL mask_window_B5 got=%b expected=0", match0);
        end
    endtask

    task automatic test_max_err();
        prog_byte(8'hFF, 8'h00);
        fill_zero();
        stream_byte(8'hFE);
        checks++;
        if (match1 !== 1'b1 || match0 !== 1'b0) begin
            errors++; $display("FAIL maxerr_FE match0=%b match1=%b expected 0/1", match0, match1);
        end
        stream_byte(8'hFC);
        checks++;
        if (match1 !== 1'b0 || match0 !== 1'b0) begin
            errors++; $display("FAIL maxerr_FC match0=%b match1=%b expected 0/0", match0, match1);
        end
    endtask

    task automatic test_hold_restart();
        prog_byte(8'hA5, 8'h00);
        fill_zero();
        stream_byte(8'hA5);
        checks++;
        if (match0 !== 1'b1) begin
            errors++; $display("FAIL hold_first_match got=%b expected=1", match0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (match0 !== 1'b0 || match1 !== 1'b0 || armed0 !== 1'b1) begin
                errors++; $display("FAIL hold_no_pulse cycle=%0d match=%b/%b armed=%b expected 0/0 armed=1", i, match0, match1, armed0);
            end
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (armed0 !== 1'b0 || match0 !== 1'b0) begin
            errors++; $display("FAIL restart_disarm armed=%b match=%b expected 0/0", armed0, match0);
        end
        for (int i = 6; i >= 0; i--) step(1'b1, i == 5 || i == 2 || i == 0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5 >> (7 - i), 1'b0);
            checks++;
            if (match0 !== 1'b0 || match1 !== 1'b0 || armed0 !== (i == 7)) begin
                errors++; $display("FAIL restart_fill cycle=%0d match=%b/%b armed=%b expected 0/0 armed=%b", i, match0, match1, armed0, i == 7);
            end
        end
    endtask

    task automatic test_saturate();
        prog_byte(8'h00, 8'hFF);
        fill_zero();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cnt1 !== 2'd3) begin
            errors++; $display("FAIL saturate_cnt got=%0d expected=3", cnt1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (cnt1 !== 2'd0 || cnt0 !== 16'd0 || match1 !== 1'b1 || match0 !== 1'b1) begin
            errors++; $display("FAIL clr_vs_match cnt=%0d/%0d match=%b/%b expected cnt 0/0 match 1/1", cnt0, cnt1, match0, match1);
        end
    endtask

    task automatic test_reset_midprog();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 clr = 1'b0;
        reset_model();
        #1;
        checks++;
        if (armed0 !== 1'b0 || match0 !== 1'b0 || cnt0 !== 16'd0 || armed1 !== 1'b0 || cnt1 !== 2'd0) begin
            errors++; $display("FAIL reset_midprog armed=%b match=%b cnt=%0d/%0d expected all 0", armed0, match0, cnt0, cnt1);
        end
        @(posedge clk);
        #2 clr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
            checks++;
            if (armed0 !== 1'b0 || match0 !== 1'b0 || match1 !== 1'b0) begin
                errors++; $display("FAIL post_reset_shift cycle=%0d armed=%b match=%b/%b expected 0", i, armed0, match0, match1);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] p, m;
        for (int s = 0; s < 20; s++) begin
            p = 8'($urandom);
            m = 8'($urandom) | 8'($urandom);
            if (s % 5 == 4) m = 8'hFF;
            for (int i = 7; i >= 0; i--) begin
                while ($urandom_range(3) == 0)
                    step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                step(1'b1, p[i], m[i], 1'($urandom), 1'($urandom), 1'b0);
                checks++;
                if (armed0 !== m_armed || match0 !== m_match[0] || cnt0 !== m_cnt[0]) begin
                    errors++; $display("FAIL rand_prog dut0 armed=%b match=%b cnt=%0d expected armed=%b match=%b cnt=%0d",
                                       armed0, match0, cnt0, m_armed, m_match[0], m_cnt[0]);
                end
            end
            for (int c = 0; c < 80; c++) begin
                step($urandom_range(59) == 0, 1'($urandom), 1'($urandom),
                     $urandom_range(2) != 0, 1'($urandom), $urandom_range(39) == 0);
                checks++;
                if (armed0 !== m_armed || match0 !== m_match[0] || cnt0 !== m_cnt[0]) begin
                    errors++; $display("FAIL rand_run dut0 armed=%b match=%b cnt=%0d expected armed=%b match=%b cnt=%0d",
                                       armed0, match0, cnt0, m_armed, m_match[0], m_cnt[0]);
                end
                checks++;
                if (armed1 !== m_armed || match1 !== m_match[1] || {14'b0, cnt1} !== m_cnt[1]) begin
                    errors++; $display("FAIL rand_run dut1 armed=%b match=%b cnt=%0d expected armed=%b match=%b cnt=%0d",
                                       armed1, match1, cnt1, m_armed, m_match[1], m_cnt[1]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_max_err();
        test_hold_restart();
        test_saturate();
        test_reset_midprog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
